udp_rx: RTL and testbench
=========================

UDP_RX -- requirements
Module: udp_rx

Interface
REQ-001 Parameter P_LOCAL_UDP_PORT, default 16'h8080, reset value of the local (accepted destination) UDP port.
REQ-002 i_clk  input  1  clock; all logic rising-edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_local_udp_port  input  16  new local port value.
REQ-005 i_local_udp_valid  input  1  one-cycle strobe loading i_local_udp_port.
REQ-006 i_ip_type  input  8  IP protocol of the current datagram; held stable while i_ip_valid.
REQ-007 i_ip_data  input  8  IP payload byte (UDP header first, MSB-first fields).
REQ-008 i_ip_valid  input  1  byte qualifier; contiguous high for one datagram, no backpressure.
REQ-009 i_ip_last  input  1  marks final IP payload byte (may include padding).
REQ-010 o_udp_data  output  8  payload byte.
REQ-011 o_udp_len  output  16  payload length = UDP length field - 8.
REQ-012 o_udp_valid  output  1  payload byte qualifier.
REQ-013 o_udp_last  output  1  final payload byte.
REQ-014 o_src_udp_port  output  16  source port of the current/last accepted datagram.
REQ-015 o_udp_err  output  1  one-cycle pulse: datagram dropped or truncated.

Function
REQ-016 FSM states IDLE, HEADER, PAYLOAD, DISCARD; byte counter cnt[15:0] counts accepted bytes from 0 within a datagram.
REQ-017 IDLE -> HEADER on i_ip_valid with i_ip_type==17 (byte 0 consumed, cnt=1); i_ip_valid with other type -> DISCARD, no o_udp_err.
REQ-018 HEADER captures bytes 0-1 src port, 2-3 dst port, 4-5 length field L; bytes 6-7 (checksum) ignored.
REQ-019 At byte 7: dst port == local port and L >= 9 -> PAYLOAD; otherwise -> DISCARD and pulse o_udp_err the following cycle.
REQ-020 i_ip_last during HEADER (fewer than 8 bytes) -> IDLE, o_udp_err pulse, no payload output.
REQ-021 PAYLOAD: input byte at cnt=k (8 <= k <= L-1) appears on o_udp_data with o_udp_valid=1 exactly one cycle later (latency 1).
REQ-022 o_udp_last=1 on the output byte for cnt=L-1; then -> DISCARD if i_ip_last not yet seen, else IDLE.
REQ-023 DISCARD drops all bytes (padding, rejected frames) until i_ip_last, then -> IDLE.
REQ-024 i_ip_last during PAYLOAD before cnt=L-1: that byte output with o_udp_last=1, o_udp_err pulsed same cycle, -> IDLE.
REQ-025 o_udp_len = L-8 and o_src_udp_port updated when entering PAYLOAD; held stable through o_udp_last and until next accepted datagram.
REQ-026 Back-to-back datagrams: i_ip_valid in the cycle after i_ip_last SHALL be accepted as byte 0 from IDLE.
REQ-027 i_local_udp_valid takes effect the next cycle; change mid-datagram does not affect a dst-port decision already made.
REQ-028 i_ip_valid low mid-datagram: state and cnt hold, no output.
REQ-029 o_udp_valid and o_udp_last are 0 outside PAYLOAD output cycles; o_udp_data is don't-care when o_udp_valid=0.

Reset
REQ-030 On i_rst: state IDLE, cnt 0, local port P_LOCAL_UDP_PORT, all outputs 0 (o_src_udp_port 0, o_udp_len 0).
REQ-031 Reset mid-datagram aborts it with no o_udp_last or o_udp_err; bytes after reset release until next i_ip_last... are treated as a new datagram starting at byte 0.

Structure
REQ-032 Shared package udp_pkg holds UDP_HDR_LEN=8, IP_PROTO_UDP=8'd17, default port 16'h8080, FSM state enum; shared with the UDP transmitter.
REQ-033 Single module, no sub-module; no FIFO (streaming, no backpressure).

Verification
REQ-034 Local port 16'h8080, datagram src 16'h1234, dst 16'h8080, L=38, 30 bytes 0x00..0x1D -> 30 output bytes, o_udp_len=30, o_src_udp_port=16'h1234, o_udp_last on 0x1D, latency 1.
REQ-035 L=12, 4 payload bytes + 14 padding bytes, i_ip_last on final pad -> exactly 4 output bytes, last on 4th, padding dropped, no err.
REQ-036 dst 16'h9000 (mismatch) -> no o_udp_valid, one o_udp_err pulse; then i_local_udp_valid with 16'h9000 and same frame -> accepted.
REQ-037 i_ip_type=6 frame of 40 bytes -> no output, no err; immediately followed (next cycle) by valid UDP frame -> fully received.
REQ-038 L=100 but i_ip_last at byte 50 -> 42 bytes output, last and err on byte 42; i_rst asserted mid-payload of next frame -> outputs 0 immediately, following frame received intact.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared UDP definitions used by the receive and transmit paths.
package udp_pkg;

    // UDP header is always eight bytes: src port, dst port, length, checksum
    localparam logic [15:0] UDP_HDR_LEN      = 16'd8;
    // Smallest length field that carries at least one payload byte
    localparam logic [15:0] UDP_MIN_LEN      = 16'd9;
    // Index of the final header byte (checksum low byte)
    localparam logic [15:0] UDP_HDR_LAST_IDX = 16'd7;
    // IP protocol number identifying UDP
    localparam logic [7:0]  IP_PROTO_UDP     = 8'd17;
    // Local port used until software programs another one
    localparam logic [15:0] UDP_DEFAULT_PORT = 16'h8080;

    // Datagram parser states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DISCARD = 2'd3
    } udp_state_t;

endpackage

// File: rtl/udp_rx.sv
// UDP receiver: strips the 8-byte UDP header from an IP payload stream,
// filters on the local destination port and forwards the payload bytes
// with one cycle of latency. Padding after the UDP length is dropped and
// short or truncated datagrams are flagged on o_udp_err.
module udp_rx
    import udp_pkg::*;
#(
    parameter logic [15:0] P_LOCAL_UDP_PORT = UDP_DEFAULT_PORT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_local_udp_port,
    input  logic        i_local_udp_valid,
    input  logic [7:0]  i_ip_type,
    input  logic [7:0]  i_ip_data,
    input  logic        i_ip_valid,
    input  logic        i_ip_last,
    output logic [7:0]  o_udp_data,
    output logic [15:0] o_udp_len,
    output logic        o_udp_valid,
    output logic        o_udp_last,
    output logic [15:0] o_src_udp_port,
    output logic        o_udp_err
);

    udp_state_t  state_r;
    logic [15:0] cnt_r;
    logic [15:0] local_port_r;
    logic [15:0] hdr_src_r;
    logic [15:0] hdr_dst_r;
    logic [15:0] hdr_len_r;

    logic        is_udp_s;
    logic        hdr_ok_s;
    logic        hdr_end_s;
    logic        pay_end_s;
    logic [15:0] len_m1_s;
    logic [15:0] cnt_inc_s;

    // Decode helpers shared by the parser: protocol match, header verdict, end markers
    always_comb begin
        is_udp_s  = (i_ip_type == IP_PROTO_UDP);
        len_m1_s  = hdr_len_r - 16'd1;
        cnt_inc_s = cnt_r + 16'd1;
        hdr_end_s = (cnt_r == UDP_HDR_LAST_IDX);
        pay_end_s = (cnt_r == len_m1_s);
        hdr_ok_s  = (hdr_dst_r == local_port_r) && (hdr_len_r >= UDP_MIN_LEN);
    end

    // Local port register; a strobe is visible to the parser from the next cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            local_port_r <= P_LOCAL_UDP_PORT;
        end else if (i_local_udp_valid) begin
            local_port_r <= i_local_udp_port;
        end else begin
            local_port_r <= local_port_r;
        end
    end

    // Datagram parser FSM with header capture and registered payload outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 16'd0;
            hdr_src_r      <= 16'd0;
            hdr_dst_r      <= 16'd0;
            hdr_len_r      <= 16'd0;
            o_udp_data     <= 8'd0;
            o_udp_len      <= 16'd0;
            o_udp_valid    <= 1'b0;
            o_udp_last     <= 1'b0;
            o_src_udp_port <= 16'd0;
            o_udp_err      <= 1'b0;
        end else begin
            // Qualifiers and the error flag are single-cycle pulses
            o_udp_valid <= 1'b0;
            o_udp_last  <= 1'b0;
            o_udp_err   <= 1'b0;

            if (i_ip_valid) begin
                case (state_r)
                    ST_IDLE: begin
                        if (is_udp_s) begin
                            hdr_src_r[15:8] <= i_ip_data;
                            if (i_ip_last) begin
                                // One-byte datagram cannot hold a header
                                o_udp_err <= 1'b1;
                                state_r   <= ST_IDLE;
                                cnt_r     <= 16'd0;
                            end else begin
                                state_r <= ST_HEADER;
                                cnt_r   <= 16'd1;
                            end
                        end else begin
                            // Other protocols are silently skipped
                            if (i_ip_last) begin
                                state_r <= ST_IDLE;
                                cnt_r   <= 16'd0;
                            end else begin
                                state_r <= ST_DISCARD;
                                cnt_r   <= 16'd1;
                            end
                        end
                    end

                    ST_HEADER: begin
                        case (cnt_r[2:0])
                            3'd1:    hdr_src_r[7:0]  <= i_ip_data;
                            3'd2:    hdr_dst_r[15:8] <= i_ip_data;
                            3'd3:    hdr_dst_r[7:0]  <= i_ip_data;
                            3'd4:    hdr_len_r[15:8] <= i_ip_data;
                            3'd5:    hdr_len_r[7:0]  <= i_ip_data;
                            default: hdr_len_r       <= hdr_len_r;
                        endcase

                        if (hdr_end_s) begin
                            if (hdr_ok_s && !i_ip_last) begin
                                // Accepted: publish length and source for this datagram
                                state_r        <= ST_PAYLOAD;
                                cnt_r          <= cnt_inc_s;
                                o_udp_len      <= hdr_len_r - UDP_HDR_LEN;
                                o_src_udp_port <= hdr_src_r;
                            end else begin
                                // Wrong port, bad length, or frame ends at the header
                                o_udp_err <= 1'b1;
                                if (i_ip_last) begin
                                    state_r <= ST_IDLE;
                                    cnt_r   <= 16'd0;
                                end else begin
                                    state_r <= ST_DISCARD;
                                    cnt_r   <= cnt_inc_s;
                                end
                            end
                        end else if (i_ip_last) begin
                            // Header cut short
                            o_udp_err <= 1'b1;
                            state_r   <= ST_IDLE;
                            cnt_r     <= 16'd0;
                        end else begin
                            state_r <= ST_HEADER;
                            cnt_r   <= cnt_inc_s;
                        end
                    end

                    ST_PAYLOAD: begin
                        o_udp_valid <= 1'b1;
                        o_udp_data  <= i_ip_data;
                        if (pay_end_s) begin
                            // Final byte per the length field; anything after is padding
                            o_udp_last <= 1'b1;
                            if (i_ip_last) begin
                                state_r <= ST_IDLE;
                                cnt_r   <= 16'd0;
                            end else begin
                                state_r <= ST_DISCARD;
                                cnt_r   <= cnt_inc_s;
                            end
                        end else if (i_ip_last) begin
                            // IP frame ended before the UDP length was reached
                            o_udp_last <= 1'b1;
                            o_udp_err  <= 1'b1;
                            state_r    <= ST_IDLE;
                            cnt_r      <= 16'd0;
                        end else begin
                            state_r <= ST_PAYLOAD;
                            cnt_r   <= cnt_inc_s;
                        end
                    end

                    ST_DISCARD: begin
                        if (i_ip_last) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= 16'd0;
                        end else begin
                            state_r <= ST_DISCARD;
                            cnt_r   <= cnt_inc_s;
                        end
                    end

                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 16'd0;
                    end
                endcase
            end else begin
                // Gap in the input stream: hold position
                state_r <= state_r;
                cnt_r   <= cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx.sv
// Self-checking bench for udp_rx: a frame-level reference model predicts,
// for every input byte, what the outputs must show one cycle later; a
// compare process checks the DUT each cycle, and directed scenarios pin
// the model with hand-computed byte counts and field values.
module tb_udp_rx;

    logic        i_clk;
    logic        i_rst;
    logic [15:0] i_local_udp_port;
    logic        i_local_udp_valid;
    logic [7:0]  i_ip_type;
    logic [7:0]  i_ip_data;
    logic        i_ip_valid;
    logic        i_ip_last;
    logic [7:0]  o_udp_data;
    logic [15:0] o_udp_len;
    logic        o_udp_valid;
    logic        o_udp_last;
    logic [15:0] o_src_udp_port;
    logic        o_udp_err;

    udp_rx #(.P_LOCAL_UDP_PORT(16'h8080)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_local_udp_port  (i_local_udp_port),
        .i_local_udp_valid (i_local_udp_valid),
        .i_ip_type         (i_ip_type),
        .i_ip_data         (i_ip_data),
        .i_ip_valid        (i_ip_valid),
        .i_ip_last         (i_ip_last),
        .o_udp_data        (o_udp_data),
        .o_udp_len         (o_udp_len),
        .o_udp_valid       (o_udp_valid),
        .o_udp_last        (o_udp_last),
        .o_src_udp_port    (o_src_udp_port),
        .o_udp_err         (o_udp_err)
    );

    typedef struct packed {
        logic        v;
        logic        l;
        logic        e;
        logic [7:0]  d;
        logic [15:0] len;
        logic [15:0] src;
    } exp_t;

    exp_t        nxt_exp;
    exp_t        cur_exp;
    int          checks;
    int          failures;
    logic [15:0] mdl_len;
    logic [15:0] mdl_src;
    logic [15:0] mdl_local;
    logic [7:0]  frame_q[$];
    int          obs_bytes;
    int          obs_err;
    logic [7:0]  obs_last_data;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Expectation for the cycle following each driven input
    always @(posedge i_clk) cur_exp <= nxt_exp;

    // Compare process and observation counters
    always @(negedge i_clk) begin
        if (i_rst) begin
            chk("rst_valid", 16'(o_udp_valid), 16'd0);
            chk("rst_last",  16'(o_udp_last),  16'd0);
            chk("rst_err",   16'(o_udp_err),   16'd0);
            chk("rst_len",   o_udp_len,        16'd0);
            chk("rst_src",   o_src_udp_port,   16'd0);
        end else begin
            chk("valid", 16'(o_udp_valid), 16'(cur_exp.v));
            chk("last",  16'(o_udp_last),  16'(cur_exp.l));
            chk("err",   16'(o_udp_err),   16'(cur_exp.e));
            chk("len",   o_udp_len,        cur_exp.len);
            chk("src",   o_src_udp_port,   cur_exp.src);
            if (cur_exp.v) chk("data", 16'(o_udp_data), 16'(cur_exp.d));
            if (o_udp_valid) begin
                obs_bytes++;
                if (o_udp_last) obs_last_data = o_udp_data;
            end
            if (o_udp_err) obs_err++;
        end
    end

    function automatic exp_t idle_exp();
        exp_t e;
        e     = '0;
        e.len = mdl_len;
        e.src = mdl_src;
        return e;
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic [7:0] t,
                        input logic lv, input logic [15:0] lp, input exp_t e);
        i_ip_valid        = v;
        i_ip_data         = d;
        i_ip_last         = l;
        i_ip_type         = t;
        i_local_udp_valid = lv;
        i_local_udp_port  = lp;
        nxt_exp           = e;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, idle_exp());
    endtask

    task automatic set_local(input logic [15:0] port);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, port, idle_exp());
        mdl_local = port;
    endtask

    task automatic clear_obs();
        obs_bytes     = 0;
        obs_err       = 0;
        obs_last_data = 8'h00;
    endtask

    task automatic do_reset();
        i_rst             = 1'b1;
        i_ip_valid        = 1'b0;
        i_ip_last         = 1'b0;
        i_local_udp_valid = 1'b0;
        mdl_len           = 16'h0000;
        mdl_src           = 16'h0000;
        mdl_local         = 16'h8080;
        nxt_exp           = idle_exp();
        #1;
        chk("rst_imm_valid", 16'(o_udp_valid), 16'd0);
        chk("rst_imm_len",   o_udp_len,        16'd0);
        chk("rst_imm_src",   o_src_udp_port,   16'd0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic build_udp(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                             input int npay, input int npad, input logic inc);
        frame_q = {};
        frame_q.push_back(src[15:8]);
        frame_q.push_back(src[7:0]);
        frame_q.push_back(dst[15:8]);
        frame_q.push_back(dst[7:0]);
        frame_q.push_back(len[15:8]);
        frame_q.push_back(len[7:0]);
        frame_q.push_back(8'($urandom));
        frame_q.push_back(8'($urandom));
        for (int i = 0; i < npay; i++) frame_q.push_back(inc ? 8'(i) : 8'($urandom));
        for (int i = 0; i < npad; i++) frame_q.push_back(8'($urandom));
    endtask

    // Drive frame_q as one IP payload and predict every output from frame-level rules
    task automatic send_frame(input logic [7:0] typ, input int gap_pct, input int rst_at,
                              input int chg_at, input logic [15:0] chg_val);
        int          n;
        int          len_i;
        int          last_out;
        logic        udp;
        logic        acc;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        exp_t        e;
        n   = frame_q.size();
        udp = (typ == 8'd17);
        src = 16'h0000;
        dst = 16'h0000;
        len = 16'h0000;
        if (n >= 6) begin
            src = {frame_q[0], frame_q[1]};
            dst = {frame_q[2], frame_q[3]};
            len = {frame_q[4], frame_q[5]};
        end
        len_i    = int'(len);
        acc      = udp && (n >= 9) && (dst == mdl_local) && (len_i >= 9);
        last_out = (len_i - 1 < n - 1) ? len_i - 1 : n - 1;
        for (int k = 0; k < n; k++) begin
            if (k == rst_at) begin
                do_reset();
                return;
            end
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
                step(1'b0, 8'($urandom), 1'b0, typ, 1'b0, 16'h0000, idle_exp());
            e = idle_exp();
            if (acc && k == 7) begin
                mdl_len = len - 16'd8;
                mdl_src = src;
                e.len   = mdl_len;
                e.src   = mdl_src;
            end
            if (acc && k >= 8 && k <= last_out) begin
                e.v = 1'b1;
                e.d = frame_q[k];
                e.l = (k == last_out);
            end
            if (udp) begin
                if (n < 8 && k == n - 1) e.e = 1'b1;
                if (n >= 8 && !acc && k == 7) e.e = 1'b1;
                if (acc && n < len_i && k == n - 1) e.e = 1'b1;
            end
            step(1'b1, frame_q[k], (k == n - 1), typ, (k == chg_at), chg_val, e);
            if (k == chg_at) mdl_local = chg_val;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int          mode;
        int          cut;
        logic [15:0] dst;
        logic [15:0] len;
        checks            = 0;
        failures          = 0;
        mdl_len           = 16'h0000;
        mdl_src           = 16'h0000;
        mdl_local         = 16'h8080;
        i_rst             = 1'b1;
        i_ip_valid        = 1'b0;
        i_ip_last         = 1'b0;
        i_ip_data         = 8'h00;
        i_ip_type         = 8'h00;
        i_local_udp_valid = 1'b0;
        i_local_udp_port  = 16'h0000;
        nxt_exp           = '0;
        clear_obs();
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        idle(2);

        // Nominal datagram: 30 payload bytes 0x00..0x1D
        clear_obs();
        build_udp(16'h1234, 16'h8080, 16'd38, 30, 0, 1'b1);
        send_frame(8'd17, 0, -1, -1, 16'h0000);
        idle(1);
        chk("t34_bytes",    16'(obs_bytes),     16'd30);
        chk("t34_lastdata", 16'(obs_last_data), 16'h001D);
        chk("t34_len",      o_udp_len,          16'd30);
        chk("t34_src",      o_src_udp_port,     16'h1234);
        chk("t34_err",      16'(obs_err),       16'd0);

        // Short length with trailing IP padding
        clear_obs();
        build_udp(16'h0A0B, 16'h8080, 16'd12, 4, 14, 1'b1);
        send_frame(8'd17, 0, -1, -1, 16'h0000);
        idle(1);
        chk("t35_bytes",    16'(obs_bytes),     16'd4);
        chk("t35_lastdata", 16'(obs_last_data), 16'h0003);
        chk("t35_err",      16'(obs_err),       16'd0);
        chk("t35_len",      o_udp_len,          16'd4);

        // Port mismatch, then reprogram the port and resend
        clear_obs();
        build_udp(16'h5555, 16'h9000, 16'd20, 12, 0, 1'b1);
        send_frame(8'd17, 0, -1, -1, 16'h0000);
        idle(1);
        chk("t36_rej_bytes", 16'(obs_bytes), 16'd0);
        chk("t36_rej_err",   16'(obs_err),   16'd1);
        set_local(16'h9000);
        clear_obs();
        send_frame(8'd17, 0, -1, -1, 16'h0000);
        idle(1);
        chk("t36_acc_bytes", 16'(obs_bytes), 16'd12);
        chk("t36_acc_src",   o_src_udp_port, 16'h5555);
        chk("t36_acc_err",   16'(obs_err),   16'd0);

        // Non-UDP frame immediately followed by a UDP frame
        set_local(16'h8080);
        clear_obs();
        frame_q = {};
        for (int i = 0; i < 40; i++) frame_q.push_back(8'($urandom));
        send_frame(8'd6, 0, -1, -1, 16'h0000);
        build_udp(16'h4321, 16'h8080, 16'd24, 16, 0, 1'b1);
        send_frame(8'd17, 0, -1, -1, 16'h0000);
        idle(1);
        chk("t37_bytes", 16'(obs_bytes), 16'd16);
        chk("t37_err",   16'(obs_err),   16'd0);
        chk("t37_src",   o_src_udp_port, 16'h4321);

        // Truncated datagram, then reset in the middle of the next payload
        clear_obs();
        build_udp(16'h7777, 16'h8080, 16'd100, 42, 0, 1'b1);
        send_frame(8'd17, 0, -1, -1, 16'h0000);
        idle(1);
        chk("t38_bytes",    16'(obs_bytes),     16'd42);
        chk("t38_err",      16'(obs_err),       16'd1);
        chk("t38_lastdata", 16'(obs_last_data), 16'h0029);
        chk("t38_len",      o_udp_len,          16'd92);
        build_udp(16'h2222, 16'h8080, 16'd40, 32, 0, 1'b1);
        send_frame(8'd17, 0, 20, -1, 16'h0000);
        clear_obs();
        build_udp(16'h3333, 16'h8080, 16'd20, 12, 0, 1'b1);
        send_frame(8'd17, 0, -1, -1, 16'h0000);
        idle(1);
        chk("t38_post_bytes", 16'(obs_bytes), 16'd12);
        chk("t38_post_src",   o_src_udp_port, 16'h3333);
        chk("t38_post_err",   16'(obs_err),   16'd0);

        // Local port changed after the header decision does not affect the datagram
        clear_obs();
        build_udp(16'h1111, 16'h8080, 16'd30, 22, 0, 1'b1);
        send_frame(8'd17, 0, -1, 10, 16'hABCD);
        idle(1);
        chk("chg_bytes", 16'(obs_bytes), 16'd22);
        set_local(16'h8080);

        // Randomized traffic: mixed protocols, lengths, padding, truncation, gaps
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 19) == 0)
                set_local(($urandom_range(0, 1) == 0) ? 16'h8080 : 16'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                frame_q = {};
                for (int i = 0; i < int'($urandom_range(1, 60)); i++) frame_q.push_back(8'($urandom));
                send_frame(8'd6, 0, -1, -1, 16'h0000);
            end else begin
                dst  = ($urandom_range(0, 9) < 7) ? mdl_local : 16'($urandom);
                len  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 8)) : 16'($urandom_range(9, 60));
                mode = int'($urandom_range(0, 2));
                if (mode == 0) begin
                    build_udp(16'($urandom), dst, len, int'($urandom_range(0, 60)), 0, 1'b0);
                end else begin
                    build_udp(16'($urandom), dst, len, (len >= 16'd8) ? int'(len) - 8 : 0,
                              int'($urandom_range(0, 10)), 1'b0);
                end
                if (mode == 2 && $urandom_range(0, 3) == 0) begin
                    cut = int'($urandom_range(1, 7));
                    while (frame_q.size() > cut) void'(frame_q.pop_back());
                end
                send_frame(8'd17, ($urandom_range(0, 1) == 0) ? 0 : 20,
                           ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 20)) : -1,
                           -1, 16'h0000);
            end
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
